// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port SRAM,
// with an optional bounded lock burst and registered read-data routing.
module sram_rr_arbiter #(
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;

  localparam logic [0:0] LAST_A = 1'b0;
  localparam logic [0:0] LAST_B = 1'b1;

  logic [1:0]    owner_q, owner_d;
  logic [0:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_rvalid_q, b_rvalid_q;

  logic          any_gnt;
  logic          win_lock;
  logic [1:0]    win_own;
  logic [CW-1:0] cnt_inc;

  // Lock owner first, then round-robin against the last winner.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (owner_q == OWN_A && a_req) begin
        a_gnt = 1'b1;
      end else if (owner_q == OWN_B && b_req) begin
        b_gnt = 1'b1;
      end else if (a_req && b_req) begin
        a_gnt = (last_q == LAST_B);
        b_gnt = (last_q == LAST_A);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  assign any_gnt = a_gnt | b_gnt;

  always_comb begin
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (a_gnt) begin
      mem_wr_en = a_we;
      mem_addr  = a_addr;
      mem_din   = a_wdata;
    end else if (b_gnt) begin
      mem_wr_en = b_we;
      mem_addr  = b_addr;
      mem_din   = b_wdata;
    end
  end

  assign win_lock = a_gnt ? a_lock : b_lock;
  assign win_own  = a_gnt ? OWN_A : OWN_B;
  assign cnt_inc  = (owner_q == win_own) ? cnt_q + CW'(1) : CW'(1);

  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (any_gnt) begin
      last_d = a_gnt ? LAST_A : LAST_B;
      if (win_lock && cnt_inc < CW'(MAX_BURST)) begin
        owner_d = win_own;
        cnt_d   = cnt_inc;
      end else begin
        owner_d = OWN_NONE;
        cnt_d   = '0;
      end
    end else if (owner_q != OWN_NONE) begin
      // No grant while owned means the owner stopped requesting.
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      last_q     <= LAST_B;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_gnt & ~a_we;
      b_rvalid_q <= b_gnt & ~b_we;
    end
  end

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? mem_dout : '0;
  assign b_rdata  = b_rvalid_q ? mem_dout : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: SRAM stand-in plus a transaction-level
// reference model of arbitration, locking and read return.
module tb_sram_rr_arbiter;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  logic       req [2];
  logic       we  [2];
  logic       lck [2];
  logic [2:0] ad  [2];
  logic [7:0] wd  [2];

  logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_wr_en;
  logic [2:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  logic [7:0] sram [8] = '{default: 8'h00};

  int errs = 0;
  int chks = 0;

  int         m_owner;
  int         m_cnt;
  int         m_last;
  logic [7:0] m_mem [8];
  logic       exp_rv [2];
  logic [7:0] exp_rd [2];

  logic [31:0] obs, exv;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  sram_rr_arbiter #(.AW(3), .DW(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_we(we[0]), .a_lock(lck[0]),
    .a_addr(ad[0]), .a_wdata(wd[0]),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(req[1]), .b_we(we[1]), .b_lock(lck[1]),
    .b_addr(ad[1]), .b_wdata(wd[1]),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Requester index that should win now, -1 for none.
  function automatic int model_win();
    if (rst) return -1;
    if (m_owner >= 0 && req[m_owner]) return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] model_vec();
    int w;
    logic g0, g1, wr;
    logic [2:0] a;
    logic [7:0] d;
    w  = model_win();
    g0 = (w == 0);
    g1 = (w == 1);
    wr = (w >= 0) ? we[w] : 1'b0;
    a  = (w >= 0) ? ad[w] : 3'd0;
    d  = (w >= 0) ? wd[w] : 8'd0;
    return {g0, g1, wr, a, d, exp_rv[0], exp_rd[0], exp_rv[1], exp_rd[1]};
  endfunction

  task automatic model_commit();
    int w;
    w = model_win();
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1;
      exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = (w == i) && !we[i];
      exp_rd[i] = exp_rv[i] ? m_mem[ad[i]] : 8'd0;
    end
    if (w >= 0) begin
      if (we[w]) m_mem[ad[w]] = wd[w];
      m_last = w;
      if (lck[w]) begin
        m_cnt = (m_owner == w) ? m_cnt + 1 : 1;
        m_owner = w;
        if (m_cnt >= MAXB) begin m_owner = -1; m_cnt = 0; end
      end else begin
        m_owner = -1; m_cnt = 0;
      end
    end else begin
      m_owner = -1; m_cnt = 0;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic l, input logic [2:0] a,
                         input logic [7:0] d);
    req[i] = r; we[i] = w; lck[i] = l; ad[i] = a; wd[i] = d;
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1, 1, 0, 3'd1, 8'hAA);
    set_req(1, 1, 1, 0, 3'd2, 8'hBB);
    for (int i = 0; i < 2; i++) begin
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL reset_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      chks++;
      if ({a_gnt, b_gnt, mem_wr_en, a_rvalid, b_rvalid} !== 5'b0) begin
        errs++;
        $display("FAIL reset_quiet%0d got=%b%b%b%b%b want=00000",
                 i, a_gnt, b_gnt, mem_wr_en, a_rvalid, b_rvalid);
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_a();
    idle();
    for (int s = 0; s < 3; s++) begin
      if (s == 0) set_req(0, 1, 1, 0, 3'd3, 8'h5A);
      if (s == 1) set_req(0, 1, 0, 0, 3'd3, 8'h00);
      if (s == 2) set_req(0, 0, 0, 0, 3'd0, 8'h00);
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL single_a_vec%0d obs=%h exp=%h", s, obs, exv);
      end
      chks++;
      if (s < 2 && a_gnt !== 1'b1) begin
        errs++; $display("FAIL single_a_gnt%0d got=%b want=1", s, a_gnt);
      end
      if (s == 2 && (a_rvalid !== 1'b1 || a_rdata !== 8'h5A)) begin
        errs++;
        $display("FAIL single_a_read got=%b/%h want=1/5a", a_rvalid, a_rdata);
      end
      tick();
    end
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 1, 0, 0, 3'd4, 8'h00);
    set_req(1, 1, 0, 0, 3'd5, 8'h00);
    for (int i = 0; i < 6; i++) begin
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL contention_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      chks++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errs++;
        $display("FAIL contention_alt%0d got=%b%b want=%s",
                 i, a_gnt, b_gnt, (i % 2 == 0) ? "A" : "B");
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock_burst();
    logic [1:0] pat [6];
    pat = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    do_reset();
    set_req(0, 1, 0, 1, 3'd6, 8'h00);
    set_req(1, 1, 0, 0, 3'd7, 8'h00);
    for (int i = 0; i < 6; i++) begin
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL burst_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      chks++;
      if ({a_gnt, b_gnt} !== pat[i]) begin
        errs++;
        $display("FAIL burst_seq%0d got=%b%b want=%b", i, a_gnt, b_gnt, pat[i]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock_release();
    logic [1:0] pat [4];
    pat = '{2'b10, 2'b10, 2'b01, 2'b10};
    do_reset();
    set_req(1, 1, 0, 0, 3'd1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) set_req(0, 1, 0, 1, 3'd2, 8'h00);
      if (i == 2) set_req(0, 0, 0, 0, 3'd0, 8'h00);
      if (i == 3) set_req(0, 1, 0, 0, 3'd2, 8'h00);
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL release_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      chks++;
      if ({a_gnt, b_gnt} !== pat[i]) begin
        errs++;
        $display("FAIL release_seq%0d got=%b%b want=%b", i, a_gnt, b_gnt, pat[i]);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(1, 1, 0, 1, 3'd0, 8'h00);
    tick();
    tick();
    rst = 1'b1;
    set_req(0, 1, 0, 0, 3'd0, 8'h00);
    tick();
    rst = 1'b0;
    #1;
    chks++; exv = model_vec();
    obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
           a_rvalid, a_rdata, b_rvalid, b_rdata};
    if (obs !== exv) begin
      errs++; $display("FAIL midburst_vec obs=%h exp=%h", obs, exv);
    end
    chks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errs++; $display("FAIL midburst_drop got=%b%b want=10", a_gnt, b_gnt);
    end
    tick();
    idle();
  endtask

  task automatic test_routing();
    idle();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set_req(0, 1, 1, 0, 3'd1, 8'h11);
      if (i == 1) begin
        set_req(0, 0, 0, 0, 3'd0, 8'h00);
        set_req(1, 1, 1, 0, 3'd2, 8'h22);
      end
      if (i == 2) begin
        set_req(0, 1, 0, 0, 3'd1, 8'h00);
        set_req(1, 1, 0, 0, 3'd2, 8'h00);
      end
      if (i == 7) idle();
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL routing_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      if (i >= 3) begin
        chks++;
        if (a_rvalid === b_rvalid ||
            (a_rvalid && {a_rdata, b_rdata} !== 16'h1100) ||
            (b_rvalid && {a_rdata, b_rdata} !== 16'h0022)) begin
          errs++;
          $display("FAIL routing_port%0d got=%b/%h %b/%h", i,
                   a_rvalid, a_rdata, b_rvalid, b_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      int w;
      rst = ($urandom_range(0, 59) == 0);
      #1;
      chks++; exv = model_vec();
      obs = {a_gnt, b_gnt, mem_wr_en, mem_addr, mem_din,
             a_rvalid, a_rdata, b_rvalid, b_rdata};
      if (obs !== exv) begin
        errs++; $display("FAIL random_vec%0d obs=%h exp=%h", i, obs, exv);
      end
      w = model_win();
      tick();
      // A requester only changes its request once granted or idle.
      for (int k = 0; k < 2; k++) begin
        if (!req[k] || w == k)
          set_req(k, ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)),
                  8'($urandom));
      end
    end
    rst = 1'b0;
    idle();
    tick();
  endtask

  initial begin
    m_owner = -1; m_cnt = 0; m_last = 1;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    exp_rv[0] = 0; exp_rv[1] = 0; exp_rd[0] = 0; exp_rd[1] = 0;
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_single_a();
    test_contention();
    test_lock_burst();
    test_lock_release();
    test_reset_mid_burst();
    do_reset();
    test_routing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
